// File: rtl/tlb_inv_ctrl_if.sv
// Request handshake and TLB read/write port bundle for the INVTLB sequencer.
// The slave modport is the controller; the master modport is the pipeline/TLB side.
interface tlb_inv_ctrl_if #(
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned ENTRY_W = 89
);
  logic               req_valid;
  logic               req_ready;
  logic [4:0]         req_op;
  logic [9:0]         req_asid;
  logic [18:0]        req_vppn;
  logic               busy;
  logic               done;
  logic               op_err;
  logic [IDX_W-1:0]   r_index;
  logic [ENTRY_W-1:0] rd_entry;
  logic               we;
  logic [IDX_W-1:0]   w_index;
  logic [ENTRY_W-1:0] wr_entry;

  modport slave (
    input  req_valid, req_op, req_asid, req_vppn, rd_entry,
    output req_ready, busy, done, op_err, r_index, we, w_index, wr_entry
  );

  modport master (
    output req_valid, req_op, req_asid, req_vppn, rd_entry,
    input  req_ready, busy, done, op_err, r_index, we, w_index, wr_entry
  );
endinterface

// File: rtl/tlb_inv_ctrl.sv
// INVTLB sequencer: walks every TLB entry via read/write ports and clears e on matches.
// Each entry takes one READ cycle (register entry + match) and one WRITE cycle.
module tlb_inv_ctrl #(
  parameter int unsigned TLBNUM  = 16,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned ENTRY_W = 89
) (
  input logic            clk,
  input logic            resetn,
  tlb_inv_ctrl_if.slave  bus
);

  // Packed entry field positions, MSB first: e, vppn, ps, asid, g, then page pairs.
  localparam int unsigned EBit    = ENTRY_W - 1;
  localparam int unsigned VppnLo  = ENTRY_W - 20;
  localparam int unsigned PsLo    = VppnLo - 6;
  localparam int unsigned AsidLo  = PsLo - 10;
  localparam int unsigned GBit    = AsidLo - 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(TLBNUM - 1);

  typedef enum logic [2:0] {StIdle, StRead, StWrite, StDone, StErr} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [4:0]         op_q, op_d;
  logic [9:0]         asid_q, asid_d;
  logic [18:0]        vppn_q, vppn_d;
  logic [ENTRY_W-1:0] ent_q, ent_d;
  logic               hit_q, hit_d;

  logic [18:0] e_vppn;
  logic [5:0]  e_ps;
  logic [9:0]  e_asid;
  logic        e_g;
  logic        asid_eq;
  logic        va_eq;
  logic        match;

  always_comb begin
    e_vppn  = bus.rd_entry[VppnLo +: 19];
    e_ps    = bus.rd_entry[PsLo +: 6];
    e_asid  = bus.rd_entry[AsidLo +: 10];
    e_g     = bus.rd_entry[GBit];
    asid_eq = (e_asid == asid_q);
    // 2MB pages (ps=21) ignore the low 9 vppn bits.
    va_eq   = (e_ps == 6'd21) ? (e_vppn[18:9] == vppn_q[18:9]) : (e_vppn == vppn_q);
    match   = 1'b0;
    case (op_q)
      5'd0, 5'd1: match = 1'b1;
      5'd2:       match = e_g;
      5'd3:       match = !e_g;
      5'd4:       match = !e_g && asid_eq;
      5'd5:       match = !e_g && asid_eq && va_eq;
      5'd6:       match = (e_g || asid_eq) && va_eq;
      default:    match = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      idx_q   <= '0;
      op_q    <= '0;
      asid_q  <= '0;
      vppn_q  <= '0;
      ent_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      asid_q  <= asid_d;
      vppn_q  <= vppn_d;
      ent_q   <= ent_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    op_d          = op_q;
    asid_d        = asid_q;
    vppn_d        = vppn_q;
    ent_d         = ent_q;
    hit_d         = hit_q;
    bus.req_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.op_err    = 1'b0;
    bus.we        = 1'b0;
    bus.r_index   = idx_q;
    bus.w_index   = idx_q;
    bus.wr_entry  = {1'b0, ent_q[ENTRY_W-2:0]};

    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        idx_d         = '0;
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          asid_d  = bus.req_asid;
          vppn_d  = bus.req_vppn;
          state_d = (bus.req_op > 5'd6) ? StErr : StRead;
        end
      end
      StRead: begin
        bus.busy = 1'b1;
        ent_d    = bus.rd_entry;
        hit_d    = match;
        state_d  = StWrite;
      end
      StWrite: begin
        bus.busy = 1'b1;
        bus.we   = hit_q && ent_q[EBit];
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = StRead;
        end
      end
      StDone: begin
        bus.done = 1'b1;
        state_d  = StIdle;
      end
      StErr: begin
        bus.done   = 1'b1;
        bus.op_err = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_tlb_inv_ctrl.sv
// Bench for tlb_inv_ctrl: a TLB array model, a per-cycle compare process driven by a
// walk-level expectation model, and directed INVTLB scenarios with literal pins.
module tb_tlb_inv_ctrl;
  localparam int N = 16;
  localparam int W = 89;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  tlb_inv_ctrl_if #(.IDX_W(4), .ENTRY_W(W)) bus ();

  tlb_inv_ctrl #(.TLBNUM(N), .IDX_W(4), .ENTRY_W(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  logic [W-1:0] tlb [N];
  assign bus.rd_entry = tlb[bus.r_index];
  always @(posedge clk) if (bus.we) tlb[bus.w_index] <= bus.wr_entry;

  int n_pass = 0;
  int n_total = 0;

  logic         exp_hit [N];
  logic [W-1:0] exp_final [N];
  bit  mon_active = 0;
  bit  mon_err = 0;
  int  mon_t = 0;
  int  lat = 0;
  int  we_cnt = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [W-1:0] mk(input logic e, input logic [18:0] vppn,
                                     input logic [5:0] ps, input logic [9:0] asid,
                                     input logic g, input logic [51:0] lo);
    return {e, vppn, ps, asid, g, lo};
  endfunction

  // Expected invalidation decision straight from the INVTLB op table.
  function automatic bit model_hit(input int op, input logic [9:0] asid,
                                   input logic [18:0] vppn, input logic [W-1:0] ent);
    logic [18:0] ev;
    int eps;
    bit ag, va, g;
    ev  = ent[87:69];
    eps = int'(ent[68:63]);
    g   = ent[52];
    ag  = (ent[62:53] == asid);
    va  = (eps == 21) ? (ev[18:9] == vppn[18:9]) : (ev == vppn);
    if (ent[88] == 1'b0) return 0;
    case (op)
      0, 1:    return 1;
      2:       return g;
      3:       return !g;
      4:       return !g && ag;
      5:       return !g && ag && va;
      6:       return (g || ag) && va;
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (bus.we) we_cnt++;
    if (!resetn) begin
    end else if (mon_active) begin
      mon_t++;
      if (bus.done) lat = mon_t;
      if (mon_err) begin
        if (mon_t == 1) begin
          chk("err_done", W'(bus.done), W'(1));
          chk("err_op_err", W'(bus.op_err), W'(1));
          chk("err_we", W'(bus.we), W'(0));
          chk("err_ready", W'(bus.req_ready), W'(0));
        end else begin
          chk("err_ready_after", W'(bus.req_ready), W'(1));
          chk("err_done_after", W'(bus.done), W'(0));
          mon_active = 0;
        end
      end else if (mon_t <= 2 * N) begin
        chk("walk_busy", W'(bus.busy), W'(1));
        chk("walk_ready", W'(bus.req_ready), W'(0));
        chk("walk_done", W'(bus.done), W'(0));
        if (mon_t % 2 == 1) begin
          chk("read_index", W'(bus.r_index), W'((mon_t - 1) / 2));
          chk("read_we", W'(bus.we), W'(0));
        end else begin
          chk("write_we", W'(bus.we), W'(exp_hit[(mon_t - 2) / 2]));
          chk("write_index", W'(bus.w_index), W'((mon_t - 2) / 2));
          if (exp_hit[(mon_t - 2) / 2])
            chk("write_data", bus.wr_entry, exp_final[(mon_t - 2) / 2]);
        end
      end else if (mon_t == 2 * N + 1) begin
        chk("done_pulse", W'(bus.done), W'(1));
        chk("done_op_err", W'(bus.op_err), W'(0));
        chk("done_busy", W'(bus.busy), W'(0));
        chk("done_ready", W'(bus.req_ready), W'(0));
      end else begin
        chk("post_ready", W'(bus.req_ready), W'(1));
        chk("post_done", W'(bus.done), W'(0));
        mon_active = 0;
      end
    end else begin
      chk("idle_ready", W'(bus.req_ready), W'(1));
      chk("idle_busy", W'(bus.busy), W'(0));
      chk("idle_done", W'(bus.done), W'(0));
      chk("idle_we", W'(bus.we), W'(0));
    end
  end

  task automatic start_req(input int op, input logic [9:0] asid, input logic [18:0] vppn);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      exp_hit[i]   = (op <= 6) && model_hit(op, asid, vppn, tlb[i]);
      exp_final[i] = exp_hit[i] ? {1'b0, tlb[i][W-2:0]} : tlb[i];
    end
    bus.req_valid = 1'b1;
    bus.req_op    = 5'(op);
    bus.req_asid  = asid;
    bus.req_vppn  = vppn;
    we_cnt = 0;
    lat = 0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    mon_t = 0;
    mon_err = (op > 6);
    mon_active = 1;
  endtask

  task automatic finish_walk(input int exp_we, input int exp_lat);
    for (int k = 0; k < 100 && mon_active; k++) @(posedge clk);
    chk("walk_end", W'(mon_active), W'(0));
    mon_active = 0;
    chk("we_count", W'(we_cnt), W'(exp_we));
    chk("latency", W'(lat), W'(exp_lat));
    for (int i = 0; i < N; i++) chk("tlb_final", tlb[i], exp_final[i]);
  endtask

  task automatic chk_reset_outs();
    chk("rst_ready", W'(bus.req_ready), W'(1));
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_done", W'(bus.done), W'(0));
    chk("rst_op_err", W'(bus.op_err), W'(0));
    chk("rst_we", W'(bus.we), W'(0));
    chk("rst_r_index", W'(bus.r_index), W'(0));
    chk("rst_w_index", W'(bus.w_index), W'(0));
    chk("rst_wr_entry", bus.wr_entry, W'(0));
  endtask

  task automatic fill(input logic g, input logic [9:0] asid, input logic [18:0] vppn);
    for (int i = 0; i < N; i++)
      tlb[i] = mk(1'b1, vppn, 6'd12, asid, g, 52'(i * 32'h0123_4567 + 32'h55));
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_asid  = '0;
    bus.req_vppn  = '0;
    fill(1'b0, 10'h0, 19'h0);
    #12;
    chk_reset_outs();
    @(negedge clk);
    resetn = 1'b1;

    // op 0: every valid entry cleared, fixed 33-cycle latency.
    for (int i = 0; i < N; i++)
      tlb[i] = mk(1'b1, 19'(i * 19'h1111), 6'(i), 10'(i), 1'(i), 52'(i * 32'h0ABC_DEF1));
    start_req(0, 10'h0, 19'h0);
    finish_walk(16, 33);
    for (int i = 0; i < N; i++) chk("t1_e_clear", W'(tlb[i][88]), W'(0));

    // op 2: only global entries 3 and 7; entry 12 is global but already invalid.
    fill(1'b0, 10'h1, 19'h7);
    tlb[3][52] = 1'b1;
    tlb[7][52] = 1'b1;
    tlb[12]    = mk(1'b0, 19'h7, 6'd12, 10'h1, 1'b1, 52'h5);
    start_req(2, 10'h0, 19'h0);
    finish_walk(2, 33);

    // op 5: non-global ASID+VA match only.
    fill(1'b1, 10'h3FF, 19'h0);
    tlb[4] = mk(1'b1, 19'h12345, 6'd12, 10'h005, 1'b0, 52'hABC);
    tlb[5] = mk(1'b1, 19'h12345, 6'd12, 10'h005, 1'b1, 52'hDEF);
    start_req(5, 10'h005, 19'h12345);
    finish_walk(1, 33);
    chk("t3_e4", W'(tlb[4][88]), W'(0));
    chk("t3_e5", W'(tlb[5][88]), W'(1));

    // op 6: 2MB page compares vppn[18:9] only; 4KB page needs the full vppn.
    fill(1'b0, 10'h100, 19'h0);
    tlb[9] = mk(1'b1, 19'h12200, 6'd21, 10'h3, 1'b0, 52'h1);
    chk("model_pin_ps21", W'(model_hit(6, 10'h3, 19'h123FF, tlb[9])), W'(1));
    start_req(6, 10'h3, 19'h123FF);
    finish_walk(1, 33);
    fill(1'b0, 10'h100, 19'h0);
    tlb[9] = mk(1'b1, 19'h12200, 6'd12, 10'h3, 1'b0, 52'h1);
    start_req(6, 10'h3, 19'h123FF);
    finish_walk(0, 33);

    // op 7: unsupported, error pulse one cycle after accept.
    fill(1'b0, 10'h0, 19'h0);
    start_req(7, 10'h0, 19'h0);
    finish_walk(0, 1);

    // Reset during READ of idx 8 aborts the op 0 walk.
    fill(1'b0, 10'h0, 19'h0);
    start_req(0, 10'h0, 19'h0);
    repeat (16) @(posedge clk);
    @(negedge clk);
    #1;
    mon_active = 0;
    resetn = 1'b0;
    #1;
    chk_reset_outs();
    for (int i = 0; i < N; i++) chk("abort_e", W'(tlb[i][88]), W'(i >= 8));
    repeat (2) @(negedge clk);
    chk("abort_no_done", W'(lat), W'(0));
    resetn = 1'b1;
    @(negedge clk);
    chk("abort_ready", W'(bus.req_ready), W'(1));
    start_req(3, 10'h0, 19'h0);
    finish_walk(8, 33);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end
endmodule
